// File: rtl/rram_host_if.sv
// Requester-side front end for the RRAM controller. Requests are buffered in a
// two-entry FIFO. Each request is launched as a single EN pulse, and the
// request fields are held on the mem_* outputs for the whole operation.
// The operation completes on EN_SA (read) or WRITE (write), or ends on a
// watchdog timeout. Exactly one response is returned per request.
module rram_host_if #(
  parameter int B_SIZE  = 4,
  parameter int X_SIZE  = 3,
  parameter int Y_SIZE  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_rw,
  input  logic [X_SIZE+Y_SIZE-1:0]   req_addr,
  input  logic [B_SIZE-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_rw,
  output logic [B_SIZE-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       mem_en,
  output logic                       mem_rw,
  output logic [X_SIZE-1:0]          mem_x_addr,
  output logic [Y_SIZE-1:0]          mem_y_addr,
  output logic [B_SIZE-1:0]          mem_wdata,
  input  logic                       mem_write,
  input  logic                       mem_en_sa,
  input  logic [B_SIZE-1:0]          mem_sa_out,
  output logic                       busy
);

  localparam int A_SIZE = X_SIZE + Y_SIZE;
  localparam int E_SIZE = 1 + A_SIZE + B_SIZE;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  // Request FIFO bookkeeping
  logic [1:0]        count_reg;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [E_SIZE-1:0] slot_data [2];
  logic [E_SIZE-1:0] head_entry;
  logic              push;
  logic              pop;

  // Operation currently owned by the FSM
  logic              op_rw_reg;
  logic [A_SIZE-1:0] op_addr_reg;
  logic [B_SIZE-1:0] op_wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [B_SIZE-1:0] rdata_reg;
  logic              err_reg;

  logic rd_done;
  logic wr_done;
  logic timed_out;

  // req_ready is forced low while reset is held, so nothing can be accepted then.
  assign req_ready  = ~reset & ~count_reg[1];
  assign push       = req_valid & req_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != 2'd0);
  assign head_entry = slot_data[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_slot
      logic [E_SIZE-1:0] slot_reg;
      // Store the incoming request when this slot is the write target.
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= {req_rw, req_addr, req_wdata};
        end
      end
      assign slot_data[gi] = slot_reg;
    end
  endgenerate

  // FIFO pointers and occupancy. A push is blocked when the FIFO is full, even if a pop happens that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Completion detection. A completion event in the last WAIT cycle takes precedence over the timeout.
  assign rd_done   = (state_reg == WAIT) &  op_rw_reg & mem_en_sa;
  assign wr_done   = (state_reg == WAIT) & ~op_rw_reg & mem_write;
  assign timed_out = (state_reg == WAIT) && (cnt_reg == CNT_LAST) && !rd_done && !wr_done;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pop) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (rd_done || wr_done || timed_out) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operation register, watchdog counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_rw_reg    <= 1'b0;
      op_addr_reg  <= '0;
      op_wdata_reg <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (pop) begin
        {op_rw_reg, op_addr_reg, op_wdata_reg} <= head_entry;
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if ((state_reg == WAIT) && (cnt_reg != CNT_LAST)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (rd_done) begin
        rdata_reg <= mem_sa_out;
        err_reg   <= 1'b0;
      end else if (wr_done) begin
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end else if (timed_out) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign mem_en     = (state_reg == ISSUE);
  assign mem_rw     = op_rw_reg;
  assign mem_x_addr = op_addr_reg[X_SIZE-1:0];
  assign mem_y_addr = op_addr_reg[A_SIZE-1:X_SIZE];
  assign mem_wdata  = op_wdata_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_rw     = op_rw_reg;
  assign rsp_rdata  = rdata_reg;
  assign rsp_err    = err_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != 2'd0);

endmodule

// File: tb/tb_rram_host_if.sv
// Testbench for rram_host_if. A behavioural controller model answers each EN
// pulse after a chosen number of WAIT cycles. Expected responses are derived
// from the request and that delay alone.
module tb_rram_host_if;
  localparam int B_SIZE  = 4;
  localparam int X_SIZE  = 3;
  localparam int Y_SIZE  = 5;
  localparam int TIMEOUT = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic                     req_rw = 1'b0;
  logic [X_SIZE+Y_SIZE-1:0] req_addr = '0;
  logic [B_SIZE-1:0]        req_wdata = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic                     rsp_rw;
  logic [B_SIZE-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic                     mem_en;
  logic                     mem_rw;
  logic [X_SIZE-1:0]        mem_x_addr;
  logic [Y_SIZE-1:0]        mem_y_addr;
  logic [B_SIZE-1:0]        mem_wdata;
  logic                     mem_write = 1'b0;
  logic                     mem_en_sa = 1'b0;
  logic [B_SIZE-1:0]        mem_sa_out = '0;
  logic                     busy;

  int vectors = 0;
  int miscompares = 0;

  // delay: WAIT-cycle index (0 = first WAIT cycle) of the completion event, -1 = never
  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [3:0] wdata;
    int         delay;
    logic [3:0] sa;
    bit         noise;
  } ctl_t;

  typedef struct {
    logic       rw;
    logic [3:0] rdata;
    logic       err;
  } rsp_t;

  ctl_t ctl_q[$];
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  rram_host_if #(
    .B_SIZE(B_SIZE), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_x_addr(mem_x_addr),
    .mem_y_addr(mem_y_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_en_sa(mem_en_sa), .mem_sa_out(mem_sa_out),
    .busy(busy)
  );

  // Expected response from the request and controller delay: the event must land within TIMEOUT WAIT cycles.
  function automatic rsp_t expect_of(input ctl_t c);
    rsp_t r;
    bit   done;
    done    = (c.delay >= 0) && (c.delay < TIMEOUT);
    r.rw    = c.rw;
    r.err   = !done;
    r.rdata = (done && c.rw) ? c.sa : 4'h0;
    return r;
  endfunction

  function automatic ctl_t rand_ctl();
    ctl_t c;
    int   r;
    c.rw    = 1'($urandom);
    c.addr  = 8'($urandom);
    c.wdata = 4'($urandom);
    c.sa    = 4'($urandom);
    c.noise = 1'($urandom);
    r = int'($urandom_range(0, 9));
    if (r == 0)      c.delay = -1;
    else if (r == 1) c.delay = TIMEOUT - 1 + int'($urandom_range(0, 2));
    else             c.delay = int'($urandom_range(0, 5));
    return c;
  endfunction

  // Controller model. It follows EN pulses, fires the completion event at
  // the chosen WAIT cycle, optionally asserts the wrong event as noise, and
  // checks that the issued fields stay stable.
  ctl_t cur;
  bit   active = 1'b0;
  bit   prev_en = 1'b0;
  int   k = 0;
  always @(negedge clk) begin
    mem_en_sa  = 1'b0;
    mem_write  = 1'b0;
    mem_sa_out = 4'($urandom);
    if (reset) begin
      active  = 1'b0;
      prev_en = 1'b0;
      ctl_q.delete();
    end else begin
      if (active) begin
        vectors++;
        if ({mem_en, mem_rw, mem_x_addr, mem_y_addr, mem_wdata} !==
            {1'b0, cur.rw, cur.addr[2:0], cur.addr[7:3], cur.wdata}) begin
          miscompares++;
          $display("FAIL mem_hold: got en=%b rw=%b x=%h y=%h wd=%h expected en=0 rw=%b x=%h y=%h wd=%h",
                   mem_en, mem_rw, mem_x_addr, mem_y_addr, mem_wdata,
                   cur.rw, cur.addr[2:0], cur.addr[7:3], cur.wdata);
        end
        if (cur.noise) begin
          if (cur.rw) mem_write = 1'b1;
          else        mem_en_sa = 1'b1;
        end
        if (k == cur.delay) begin
          if (cur.rw) begin
            mem_en_sa  = 1'b1;
            mem_sa_out = cur.sa;
          end else begin
            mem_write = 1'b1;
          end
          active = 1'b0;
        end
        k++;
        if (k > TIMEOUT + 1) active = 1'b0;
      end
      if (mem_en) begin
        vectors++;
        if (prev_en) begin
          miscompares++;
          $display("FAIL mem_en_pulse: got en high two cycles running, expected single-cycle pulse");
        end
        vectors++;
        if (ctl_q.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected: got mem_en=1 expected no pending request");
        end else begin
          cur    = ctl_q.pop_front();
          active = 1'b1;
          k      = 0;
          vectors++;
          if ({mem_rw, mem_x_addr, mem_y_addr, mem_wdata} !==
              {cur.rw, cur.addr[2:0], cur.addr[7:3], cur.wdata}) begin
            miscompares++;
            $display("FAIL issue_fields: got rw=%b x=%h y=%h wd=%h expected rw=%b x=%h y=%h wd=%h",
                     mem_rw, mem_x_addr, mem_y_addr, mem_wdata,
                     cur.rw, cur.addr[2:0], cur.addr[7:3], cur.wdata);
          end
        end
      end
      prev_en = mem_en;
    end
  end

  task automatic set_req(input ctl_t c);
    req_valid = 1'b1;
    req_rw    = c.rw;
    req_addr  = c.addr;
    req_wdata = c.wdata;
  endtask

  // Present a request at the current negedge, wait (bounded) for acceptance, then record it in the model.
  task automatic send_req(input ctl_t c);
    int guard = 0;
    set_req(c);
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept: got req_ready=0 for %0d cycles expected acceptance", guard);
    end else begin
      ctl_q.push_back(c);
      exp_q.push_back(expect_of(c));
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Consume n responses (optionally with random backpressure) and compare each in order.
  task automatic drain(input int n, input bit rnd);
    int   got = 0;
    int   guard = 0;
    rsp_t e;
    while (got < n && guard < 4000) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_extra: got rw=%b rdata=%h err=%b expected no response",
                   rsp_rw, rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_rw, rsp_rdata, rsp_err} !== {e.rw, e.rdata, e.err}) begin
            miscompares++;
            $display("FAIL rsp_payload: got rw=%b rdata=%h err=%b expected rw=%b rdata=%h err=%b",
                     rsp_rw, rsp_rdata, rsp_err, e.rw, e.rdata, e.err);
          end
        end
        got++;
      end
      @(negedge clk);
      guard++;
    end
    if (got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d responses expected %0d", got, n);
    end
    rsp_ready = 1'b1;
  endtask

  // Single request with an idle controller and rsp_ready held high. Cycle 0 is the acceptance cycle.
  task automatic run_single(input ctl_t c, input int rsp_cycle);
    rsp_t e;
    e = expect_of(c);
    rsp_ready = 1'b1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", req_ready);
    end
    set_req(c);
    ctl_q.push_back(c);
    for (int t = 1; t <= rsp_cycle + 1; t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      vectors++;
      if (mem_en !== (t == 2)) begin
        miscompares++;
        $display("FAIL single_mem_en: cycle %0d got %b expected %b", t, mem_en, (t == 2));
      end
      vectors++;
      if (rsp_valid !== (t == rsp_cycle)) begin
        miscompares++;
        $display("FAIL single_rsp_valid: cycle %0d got %b expected %b", t, rsp_valid, (t == rsp_cycle));
      end
      if (t == 2) begin
        vectors++;
        if ({mem_rw, mem_x_addr, mem_y_addr, mem_wdata} !==
            {c.rw, c.addr[2:0], c.addr[7:3], c.wdata}) begin
          miscompares++;
          $display("FAIL single_issue: got rw=%b x=%0d y=%0d wd=%h expected rw=%b x=%0d y=%0d wd=%h",
                   mem_rw, mem_x_addr, mem_y_addr, mem_wdata,
                   c.rw, c.addr[2:0], c.addr[7:3], c.wdata);
        end
      end
      if (t == rsp_cycle) begin
        vectors++;
        if ({rsp_rw, rsp_rdata, rsp_err} !== {e.rw, e.rdata, e.err}) begin
          miscompares++;
          $display("FAIL single_payload: got rw=%b rdata=%h err=%b expected rw=%b rdata=%h err=%b",
                   rsp_rw, rsp_rdata, rsp_err, e.rw, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err, mem_en, mem_rw,
         mem_x_addr, mem_y_addr, mem_wdata, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b en=%b rw=%b x=%h y=%h wd=%h busy=%b expected all 0",
               req_ready, rsp_valid, mem_en, mem_rw, mem_x_addr, mem_y_addr, mem_wdata, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b rsp_valid=%b expected 1 0 0",
               req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_read();
    ctl_t c;
    c = '{rw: 1'b1, addr: {5'd17, 3'd6}, wdata: 4'($urandom), delay: 2, sa: 4'hA, noise: 1'b0};
    run_single(c, 6);
  endtask

  task automatic test_write();
    ctl_t c;
    c = '{rw: 1'b0, addr: {5'd0, 3'd7}, wdata: 4'h5, delay: 0, sa: 4'h0, noise: 1'b0};
    run_single(c, 4);
  endtask

  task automatic test_timeout_edge();
    ctl_t c;
    c = '{rw: 1'b1, addr: 8'($urandom), wdata: 4'($urandom), delay: TIMEOUT - 1,
          sa: 4'($urandom), noise: 1'b0};
    run_single(c, 4 + TIMEOUT - 1);
  endtask

  // Read that never completes, followed by a queued write. The read times out; the write then issues normally.
  task automatic test_timeout();
    ctl_t c1, c2;
    int   r1, i2, r2;
    c1 = '{rw: 1'b1, addr: 8'($urandom), wdata: 4'($urandom), delay: -1, sa: 4'h0, noise: 1'b0};
    c2 = '{rw: 1'b0, addr: 8'($urandom), wdata: 4'($urandom), delay: 1, sa: 4'h0, noise: 1'b0};
    r1 = 3 + TIMEOUT;
    i2 = r1 + 2;
    r2 = i2 + 1 + c2.delay + 1;
    rsp_ready = 1'b1;
    set_req(c1);
    ctl_q.push_back(c1);
    for (int t = 1; t <= r2 + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        set_req(c2);
        ctl_q.push_back(c2);
      end
      if (t == 2) req_valid = 1'b0;
      vectors++;
      if (mem_en !== (t == 2 || t == i2)) begin
        miscompares++;
        $display("FAIL timeout_mem_en: cycle %0d got %b expected %b", t, mem_en, (t == 2 || t == i2));
      end
      vectors++;
      if (rsp_valid !== (t == r1 || t == r2)) begin
        miscompares++;
        $display("FAIL timeout_rsp_valid: cycle %0d got %b expected %b", t, rsp_valid, (t == r1 || t == r2));
      end
      if (t == r1) begin
        vectors++;
        if ({rsp_rw, rsp_rdata, rsp_err} !== {1'b1, 4'h0, 1'b1}) begin
          miscompares++;
          $display("FAIL timeout_payload: got rw=%b rdata=%h err=%b expected rw=1 rdata=0 err=1",
                   rsp_rw, rsp_rdata, rsp_err);
        end
      end
      if (t == r2) begin
        vectors++;
        if ({rsp_rw, rsp_rdata, rsp_err} !== {1'b0, 4'h0, 1'b0}) begin
          miscompares++;
          $display("FAIL after_timeout_payload: got rw=%b rdata=%h err=%b expected rw=0 rdata=0 err=0",
                   rsp_rw, rsp_rdata, rsp_err);
        end
      end
    end
  endtask

  // With rsp_ready low, up to three requests fit: one is held by the FSM
  // and two more are queued. The fourth request stalls until responses
  // start draining.
  task automatic test_back_to_back();
    ctl_t a, b, c, d;
    a = '{rw: 1'b1, addr: 8'($urandom), wdata: 4'($urandom), delay: 1, sa: 4'($urandom), noise: 1'b0};
    b = '{rw: 1'b0, addr: 8'($urandom), wdata: 4'($urandom), delay: 0, sa: 4'h0, noise: 1'b0};
    c = '{rw: 1'b1, addr: 8'($urandom), wdata: 4'($urandom), delay: 3, sa: 4'($urandom), noise: 1'b0};
    d = '{rw: 1'b0, addr: 8'($urandom), wdata: 4'($urandom), delay: 2, sa: 4'h0, noise: 1'b0};
    rsp_ready = 1'b0;
    send_req(a);
    send_req(b);
    send_req(c);
    set_req(d);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_stall: step %0d got req_ready=%b expected 0", i, req_ready);
      end
      @(negedge clk);
    end
    vectors++;
    if ({rsp_valid, rsp_rw, rsp_err} !== {1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_hold: got valid=%b rw=%b err=%b expected valid=1 rw=1 err=0",
               rsp_valid, rsp_rw, rsp_err);
    end
    fork
      send_req(d);
      drain(4, 1'b0);
    join
  endtask

  // Reset during WAIT with a second request queued. Everything is dropped and no response appears.
  task automatic test_reset_mid();
    ctl_t c1, c2;
    c1 = '{rw: 1'b1, addr: 8'($urandom), wdata: 4'($urandom), delay: -1, sa: 4'h0, noise: 1'b0};
    c2 = '{rw: 1'b0, addr: 8'($urandom), wdata: 4'($urandom), delay: 0, sa: 4'h0, noise: 1'b0};
    rsp_ready = 1'b1;
    set_req(c1);
    ctl_q.push_back(c1);
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (t == 1) begin
        set_req(c2);
        ctl_q.push_back(c2);
      end
      if (t == 2) req_valid = 1'b0;
      if (t == 4) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
        reset = 1'b1;
      end
      if (t == 5) begin
        vectors++;
        if ({mem_en, busy, rsp_valid, req_ready} !== 4'b0000) begin
          miscompares++;
          $display("FAIL midreset_abort: got en=%b busy=%b rv=%b rdy=%b expected 0 0 0 0",
                   mem_en, busy, rsp_valid, req_ready);
        end
      end
      if (t == 6) reset = 1'b0;
      if (t >= 7) begin
        vectors++;
        if ({mem_en, busy, rsp_valid, req_ready} !== 4'b0001) begin
          miscompares++;
          $display("FAIL midreset_after: cycle %0d got en=%b busy=%b rv=%b rdy=%b expected 0 0 0 1",
                   t, mem_en, busy, rsp_valid, req_ready);
        end
      end
    end
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_req(rand_ctl());
        end
      end
      drain(40, 1'b1);
    join
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, rsp_valid} !== 2'b00 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_end: got busy=%b rsp_valid=%b pending=%0d expected 0 0 0",
               busy, rsp_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    @(negedge clk);
    test_write();
    @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_timeout();
    @(negedge clk);
    test_timeout_edge();
    @(negedge clk);
    test_reset_mid();
    exp_q.delete();
    @(negedge clk);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
